wb_rr_arbiter: RTL

// - Parametrised writeback arbiter: collects results from NUM_UNITS execution units into per-unit FIFOs.
// - Each cycle, drives up to NUM_PORTS registered wb_packet_t writebacks, granted round-robin.
// - Sits between the execution units and register-file writeback.
// - Generalises the single fixed wb_packet_t path to N units x P ports, with buffering and fairness.

---
 rtl/wb_rr_arbiter_pkg.sv | 21 ++
 rtl/wb_unit_fifo.sv | 49 ++++
 rtl/wb_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types for the writeback arbiter: instruction id, writeback packet and FIFO entry.
// Mirrors the id_t / wb_packet_t layout of the core's type package.
package wb_rr_arbiter_pkg;

    localparam int MAX_IDS = 8;
    localparam int ID_W    = $clog2(MAX_IDS);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic        valid;
        logic [31:0] data;
    } wb_packet_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/wb_unit_fifo.sv
// Per-unit result FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module wb_unit_fifo
    import wb_rr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  fifo_entry_t din_i,
    output fifo_entry_t dout_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fifo_entry_t mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin writeback arbiter: NUM_UNITS buffered producers onto NUM_PORTS registered ports.
// Define WB_ARB_STATS_EN to build the saturating per-unit stall counters.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int NUM_PORTS = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  id_t  [NUM_UNITS-1:0]        unit_id,
    input  logic [NUM_UNITS-1:0][31:0]  unit_data,
    output logic [NUM_UNITS-1:0]        unit_ack,
    output wb_packet_t [NUM_PORTS-1:0]  wb,
    output logic [NUM_UNITS-1:0][31:0]  stall_count
);

    localparam int GW = $clog2(NUM_UNITS);
    typedef logic [GW-1:0] wb_arb_grant_t;

    logic [NUM_UNITS-1:0] full, empty, grant;
    fifo_entry_t          head [NUM_UNITS];

    logic          [NUM_PORTS-1:0] port_vld;
    wb_arb_grant_t [NUM_PORTS-1:0] port_sel;
    wb_arb_grant_t                 last_idx;
    wb_arb_grant_t                 rr_ptr_q, rr_ptr_d;
    wb_packet_t    [NUM_PORTS-1:0] wb_q, wb_d;

    // No bypass: a full FIFO refuses the push even when it is popped this cycle.
    assign unit_ack = unit_valid & ~full;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_fifo
        fifo_entry_t din;
        assign din.id   = unit_id[i];
        assign din.data = unit_data[i];

        wb_unit_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (unit_ack[i]),
            .pop_i   (grant[i]),
            .din_i   (din),
            .dout_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    // NOTE: every combinational output is given a default first so no path can infer a latch.
    always_comb begin
        logic [GW:0] pos;
        int          n_grants;
        grant    = '0;
        port_vld = '0;
        port_sel = '0;
        last_idx = rr_ptr_q;
        pos      = '0;
        n_grants = 0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            pos = {1'b0, rr_ptr_q} + (GW+1)'(j);
            if (pos >= (GW+1)'(NUM_UNITS)) pos = pos - (GW+1)'(NUM_UNITS);
            if (!empty[pos[GW-1:0]] && n_grants < NUM_PORTS) begin
                grant[pos[GW-1:0]] = 1'b1;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (k == n_grants) begin
                        port_vld[k] = 1'b1;
                        port_sel[k] = pos[GW-1:0];
                    end
                end
                last_idx = pos[GW-1:0];
                n_grants++;
            end
        end
    end

    always_comb begin
        wb_d     = wb_q;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            wb_d[k].valid = port_vld[k];
            if (port_vld[k]) begin
                wb_d[k].id   = head[port_sel[k]].id;
                wb_d[k].data = head[port_sel[k]].data;
            end
        end
        if (|grant) begin
            rr_ptr_d = (last_idx == wb_arb_grant_t'(NUM_UNITS - 1)) ? '0
                                                                    : last_idx + wb_arb_grant_t'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            wb_q     <= wb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign wb = wb_q;

`ifdef WB_ARB_STATS_EN
    logic [NUM_UNITS-1:0][31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!empty[i] && !grant[i] && stall_q[i] != 32'hFFFF_FFFF) stall_d[i] = stall_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
